// File: rtl/riscv_pkg.sv
// Shared encodings and pipeline-register layouts for the RV32 back-end.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package riscv_pkg;

    // ALU operation select
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Writeback result select; 2'b11 is unused and yields zero
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic [1:0]  result_src;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] pc_plus4;
    } ex_mem_t;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [31:0] pc_plus4;
    } mem_wb_t;

    function automatic logic [31:0] result_mux(
        input logic [1:0]  sel,
        input logic [31:0] alu_res,
        input logic [31:0] mem_res,
        input logic [31:0] pc4_res
    );
        logic [31:0] r;
        r = '0;
        case (sel)
            RES_ALU: r = alu_res;
            RES_MEM: r = mem_res;
            RES_PC4: r = pc4_res;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/execute_mem_wb_cycle_alu.sv
// 32-bit integer ALU for the execute stage (add/sub/and/or/xor/signed slt).
// Latency: purely combinational.
// Backpressure: none.
// Ports: src_a, src_b operands; alu_control op select; result, zero flag.
module alu
    import riscv_pkg::*;
(
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [2:0]  alu_control,
    output logic [31:0] result,
    output logic        zero
);

    logic slt_bit;

    always_comb begin
        slt_bit = ($signed(src_a) < $signed(src_b));
        result  = '0;
        case (alu_control)
            ALU_ADD: result = src_a + src_b;
            ALU_SUB: result = src_a - src_b;
            ALU_AND: result = src_a & src_b;
            ALU_OR:  result = src_a | src_b;
            ALU_XOR: result = src_a ^ src_b;
            ALU_SLT: result = {31'd0, slt_bit};
            default: result = '0;
        endcase
        zero = (result == 32'd0);
    end

endmodule

// File: rtl/execute_mem_wb_cycle.sv
// RV32 back-end: execute (ALU, redirect), EX/MEM reg, word data memory, MEM/WB reg.
// Latency: redirect combinational; writeback two clock edges after the E cycle.
// Backpressure: none; hazards are resolved upstream, every cycle advances.
// Ports: E-stage operands/controls in; PCSrcE/PCTargetE redirect out;
//        RegWriteM/RdM for hazard detection; RegWriteW/RdW/ResultW to regfile.
module execute_mem_wb_cycle
    import riscv_pkg::*;
#(
    parameter int DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [31:0] ImmExtE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [4:0]  RdE,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        JumpE,
    input  logic        jalrE,
    input  logic        BranchE,
    input  logic        ALUSrcE,
    input  logic [2:0]  ALUControlE,
    input  logic [1:0]  ResultSrcE,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic [4:0]  RdM,
    output logic        RegWriteW,
    output logic [4:0]  RdW,
    output logic [31:0] ResultW
);

    localparam int AW = $clog2(DMEM_WORDS);

    // ---------------- execute ----------------
    logic [31:0] src_b_e;
    logic [31:0] alu_result_e;
    logic        zero_e;
    logic [31:0] jalr_sum_e;

    assign src_b_e = ALUSrcE ? ImmExtE : RD2_E;

    alu u_alu (
        .src_a       (RD1_E),
        .src_b       (src_b_e),
        .alu_control (ALUControlE),
        .result      (alu_result_e),
        .zero        (zero_e)
    );

    // beq only: the branch compare is the SUB result being zero
    assign jalr_sum_e = RD1_E + ImmExtE;
    assign PCSrcE     = JumpE | (BranchE & zero_e);
    assign PCTargetE  = jalrE ? {jalr_sum_e[31:1], 1'b0} : (PCE + ImmExtE);

    // ---------------- pipeline registers ----------------
    ex_mem_t ex_mem_d, ex_mem_q;
    mem_wb_t mem_wb_d, mem_wb_q;

    logic [31:0] dmem [DMEM_WORDS];
    logic [AW-1:0] dmem_idx;
    logic          dmem_we;
    logic [31:0]   read_data_m;

    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.reg_write  = RegWriteE;
        ex_mem_d.mem_write  = MemWriteE;
        ex_mem_d.result_src = ResultSrcE;
        ex_mem_d.rd         = RdE;
        ex_mem_d.alu_result = alu_result_e;
        ex_mem_d.write_data = RD2_E;
        ex_mem_d.pc_plus4   = PCPlus4E;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    // ---------------- memory ----------------
    // Word index taken straight from the address: byte offset dropped and
    // upper bits ignored, so addresses alias modulo the memory depth.
    assign dmem_idx    = ex_mem_q.alu_result[AW+1:2];
    assign read_data_m = dmem[dmem_idx];
    // Gating on rst keeps a store caught in M by a reset from landing.
    assign dmem_we     = ex_mem_q.mem_write & rst;

    always_ff @(posedge clk) begin
        if (dmem_we) begin
            dmem[dmem_idx] <= ex_mem_q.write_data;
        end
    end

    always_comb begin
        mem_wb_d            = '0;
        mem_wb_d.reg_write  = ex_mem_q.reg_write;
        mem_wb_d.result_src = ex_mem_q.result_src;
        mem_wb_d.rd         = ex_mem_q.rd;
        mem_wb_d.alu_result = ex_mem_q.alu_result;
        mem_wb_d.read_data  = read_data_m;
        mem_wb_d.pc_plus4   = ex_mem_q.pc_plus4;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_wb_q <= '0;
        end else begin
            mem_wb_q <= mem_wb_d;
        end
    end

    // ---------------- outputs ----------------
    assign RegWriteM = ex_mem_q.reg_write;
    assign RdM       = ex_mem_q.rd;
    assign RegWriteW = mem_wb_q.reg_write;
    assign RdW       = mem_wb_q.rd;
    assign ResultW   = result_mux(mem_wb_q.result_src, mem_wb_q.alu_result,
                                  mem_wb_q.read_data, mem_wb_q.pc_plus4);

endmodule

// File: tb/tb_execute_mem_wb_cycle.sv
// Randomized self-checking bench for execute_mem_wb_cycle against a
// sequential instruction-level reference model, plus directed cases.
module tb_execute_mem_wb_cycle;

    logic        clk;
    logic        rst;
    logic [31:0] pce, pcplus4e, immexte, rd1_e, rd2_e;
    logic [4:0]  rde;
    logic        regwritee, memwritee, jumpe, jalre, branche, alusrce;
    logic [2:0]  aluctrle;
    logic [1:0]  resultsrce;
    logic        pcsrce;
    logic [31:0] pctargete;
    logic        regwritem;
    logic [4:0]  rdm;
    logic        regwritew;
    logic [4:0]  rdw;
    logic [31:0] resultw;

    execute_mem_wb_cycle #(.DMEM_WORDS(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .PCE         (pce),
        .PCPlus4E    (pcplus4e),
        .ImmExtE     (immexte),
        .RD1_E       (rd1_e),
        .RD2_E       (rd2_e),
        .RdE         (rde),
        .RegWriteE   (regwritee),
        .MemWriteE   (memwritee),
        .JumpE       (jumpe),
        .jalrE       (jalre),
        .BranchE     (branche),
        .ALUSrcE     (alusrce),
        .ALUControlE (aluctrle),
        .ResultSrcE  (resultsrce),
        .PCSrcE      (pcsrce),
        .PCTargetE   (pctargete),
        .RegWriteM   (regwritem),
        .RdM         (rdm),
        .RegWriteW   (regwritew),
        .RdW         (rdw),
        .ResultW     (resultw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        logic        jump;
        logic        jalr;
        logic        branch;
        logic        alusrc;
        logic [2:0]  op;
        logic [1:0]  rsrc;
    } instr_t;

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] res;
    } wb_t;

    instr_t      e;
    wb_t         exp_q[$];
    logic [31:0] mm [64];
    logic        pend_vld;
    int          pend_idx;
    logic [31:0] pend_dat;
    logic        obs_pcsrc;
    logic [31:0] obs_tgt;
    int          errs;
    int          checks;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Architectural meaning of each ALU op, written as plain arithmetic
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a + (~b) + 32'd1;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr >> 2) % 32'd64);
    endfunction

    task automatic drive_e();
        pce = e.pc; pcplus4e = e.pc4; immexte = e.imm;
        rd1_e = e.rd1; rd2_e = e.rd2; rde = e.rd;
        regwritee = e.rw; memwritee = e.mw; jumpe = e.jump; jalre = e.jalr;
        branche = e.branch; alusrce = e.alusrc; aluctrle = e.op; resultsrce = e.rsrc;
    endtask

    // Check the oldest expected writeback against the W outputs
    task automatic check_w();
        wb_t w;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            w = exp_q.pop_front();
            chk("RegWriteW", 32'(regwritew), 32'(w.rw));
            chk("RdW", 32'(rdw), 32'(w.rd));
            chk("ResultW", resultw, w.res);
        end
    endtask

    // One instruction through E; the model treats instructions as executing
    // in program order, with a store becoming visible to later instructions
    // unless a reset lands while it is still pending.
    task automatic issue();
        logic [31:0] srcb, alu, tgt, sum, res;
        logic        redirect;
        wb_t         w;
        @(negedge clk);
        rst = 1'b1;
        drive_e();
        #1;
        srcb     = e.alusrc ? e.imm : e.rd2;
        alu      = alu_ref(e.rd1, srcb, e.op);
        redirect = e.jump | (e.branch & (alu == 32'd0));
        sum      = e.rd1 + e.imm;
        tgt      = e.jalr ? (sum - (sum % 32'd2)) : (e.pc + e.imm);
        obs_pcsrc = pcsrce;
        obs_tgt   = pctargete;
        chk("PCSrcE", 32'(pcsrce), 32'(redirect));
        chk("PCTargetE", pctargete, tgt);
        if (pend_vld) mm[pend_idx] = pend_dat;
        pend_vld = 1'b0;
        case (e.rsrc)
            2'd0:    res = alu;
            2'd1:    res = mm[word_of(alu)];
            2'd2:    res = e.pc4;
            default: res = 32'd0;
        endcase
        w.rw = e.rw; w.rd = e.rd; w.res = res;
        exp_q.push_back(w);
        if (e.mw) begin
            pend_vld = 1'b1;
            pend_idx = word_of(alu);
            pend_dat = e.rd2;
        end
        @(posedge clk);
        #1;
        chk("RegWriteM", 32'(regwritem), 32'(e.rw));
        chk("RdM", 32'(rdm), 32'(e.rd));
        check_w();
    endtask

    // A cycle with reset low: whatever is in E and M is dropped
    task automatic reset_cycle();
        wb_t z;
        @(negedge clk);
        rst = 1'b0;
        e = '0;
        drive_e();
        pend_vld = 1'b0;
        z.rw = 1'b0; z.rd = 5'd0; z.res = 32'd0;
        exp_q.delete();
        exp_q.push_back(z);
        exp_q.push_back(z);
        @(posedge clk);
        #1;
        chk("rst_RegWriteM", 32'(regwritem), 32'd0);
        chk("rst_RdM", 32'(rdm), 32'd0);
        check_w();
    endtask

    function automatic logic [31:0] rnd_val();
        if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 15));
        return $urandom();
    endfunction

    logic [31:0] old_word;

    initial begin
        errs = 0; checks = 0; pend_vld = 1'b0; pend_idx = 0; pend_dat = '0;
        rst = 1'b0;
        e = '0;
        drive_e();
        reset_cycle();
        reset_cycle();
        chk("reset_RegWriteW", 32'(regwritew), 32'd0);
        chk("reset_RdW", 32'(rdw), 32'd0);
        chk("reset_ResultW", resultw, 32'd0);

        // Fill every data word so later random loads read known contents
        for (int i = 0; i < 64; i++) begin
            e = '0;
            e.mw = 1'b1; e.alusrc = 1'b1;
            e.rd1 = ($urandom() & 32'hFFFF_FF00) | (32'(i) << 2) | 32'($urandom_range(0, 3));
            e.rd2 = $urandom();
            issue();
        end

        // add 5 + 7 into x3
        e = '0; e.rd1 = 32'd5; e.rd2 = 32'd7; e.rd = 5'd3; e.rw = 1'b1;
        issue();
        e = '0; issue();
        chk("add_rw", 32'(regwritew), 32'd1);
        chk("add_rd", 32'(rdw), 32'd3);
        chk("add_res", resultw, 32'd12);

        // sw to 0x10, then lw 0x10 and lw 0x110 (aliases the same word)
        e = '0; e.rd1 = 32'h10; e.alusrc = 1'b1; e.rd2 = 32'hDEAD_BEEF; e.mw = 1'b1;
        issue();
        e = '0; e.rd1 = 32'h10; e.alusrc = 1'b1; e.rsrc = 2'b01; e.rw = 1'b1; e.rd = 5'd5;
        issue();
        e = '0; e.rd1 = 32'h100; e.imm = 32'h10; e.alusrc = 1'b1; e.rsrc = 2'b01;
        e.rw = 1'b1; e.rd = 5'd6;
        issue();
        chk("lw_0x10", resultw, 32'hDEAD_BEEF);
        e = '0; issue();
        chk("lw_0x110_alias", resultw, 32'hDEAD_BEEF);

        // beq taken, then not taken
        e = '0; e.rd1 = 32'd9; e.rd2 = 32'd9; e.branch = 1'b1; e.op = 3'b001;
        e.pc = 32'h40; e.imm = 32'h20;
        issue();
        chk("beq_taken", 32'(obs_pcsrc), 32'd1);
        chk("beq_target", obs_tgt, 32'h60);
        e.rd2 = 32'd8;
        issue();
        chk("beq_not_taken", 32'(obs_pcsrc), 32'd0);

        // jalr: target cleared of bit 0, link value is PC+4
        e = '0; e.rd1 = 32'h101; e.imm = 32'd4; e.jump = 1'b1; e.jalr = 1'b1;
        e.alusrc = 1'b1; e.pc4 = 32'h1C; e.rsrc = 2'b10; e.rw = 1'b1; e.rd = 5'd1;
        issue();
        chk("jalr_pcsrc", 32'(obs_pcsrc), 32'd1);
        chk("jalr_target", obs_tgt, 32'h104);
        e = '0; issue();
        chk("jalr_link", resultw, 32'h1C);

        // signed slt both ways
        e = '0; e.rd1 = 32'hFFFF_FFFF; e.rd2 = 32'd1; e.op = 3'b101; e.rw = 1'b1; e.rd = 5'd4;
        issue();
        e.rd1 = 32'd1; e.rd2 = 32'hFFFF_FFFF;
        issue();
        chk("slt_neg_lt_pos", resultw, 32'd1);
        e = '0; issue();
        chk("slt_pos_lt_neg", resultw, 32'd0);

        // store caught in M by reset must not write
        e = '0; issue();
        old_word = mm[8];
        e = '0; e.rd1 = 32'h20; e.alusrc = 1'b1; e.rd2 = 32'hCAFE_F00D; e.mw = 1'b1;
        e.rw = 1'b1; e.rd = 5'd7;
        issue();
        reset_cycle();
        chk("rst_store_RegWriteW", 32'(regwritew), 32'd0);
        chk("rst_store_ResultW", resultw, 32'd0);
        e = '0; e.rd1 = 32'h20; e.alusrc = 1'b1; e.rsrc = 2'b01; e.rw = 1'b1; e.rd = 5'd8;
        issue();
        e = '0; issue();
        chk("rst_store_dropped", resultw, old_word);

        // Random instruction stream with occasional resets
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset_cycle();
            end else begin
                e.pc     = $urandom();
                e.pc4    = e.pc + 32'd4;
                e.imm    = rnd_val();
                e.rd1    = rnd_val();
                e.rd2    = ($urandom_range(0, 3) == 0) ? e.rd1 : rnd_val();
                e.rd     = 5'($urandom_range(0, 31));
                e.rw     = 1'($urandom_range(0, 1));
                e.mw     = 1'($urandom_range(0, 1));
                e.jump   = ($urandom_range(0, 3) == 0);
                e.jalr   = 1'($urandom_range(0, 1));
                e.branch = 1'($urandom_range(0, 1));
                e.alusrc = 1'($urandom_range(0, 1));
                e.op     = 3'($urandom_range(0, 7));
                e.rsrc   = 2'($urandom_range(0, 3));
                issue();
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
